wb_host_arb: RTL and testbench
==============================

// Module: wb_host_arb
// PURPOSE
//  Two-port arbiter sharing the single 8-bit register port of the wishbone master.
//  That port gives access to the SB_SPI/SB_I2C hard IP.
//  Port A is the CPU; port B is an autonomous engine (e.g. LCD SPI streamer).
//  Round-robin grant with optional per-port lock for multi-register sequences.
//  A watchdog terminates hung transactions with an error flag.
// PARAMETERS
//  TO_BITS   8    width of timeout counter; timeout = 2**TO_BITS-1 cycles after grant
//  A_FIRST   1    after reset, port A wins a simultaneous first request
// PORTS
//  clk       in   1  system clock
//  rst       in   1  asynchronous active-low reset
//  a_cs      in   1  port A request; held with a_we/a_addr/a_din until a_rdy
//  a_we      in   1  port A write enable
//  a_lock    in   1  port A keep grant after current transfer
//  a_addr    in   8  port A register select
//  a_din     in   8  port A write data
//  a_dout    out  8  port A read data, valid when a_rdy
//  a_rdy     out  1  port A one-cycle completion pulse
//  a_err     out  1  port A timeout flag, valid with a_rdy
//  b_*       -    -  identical set for port B
//  m_cs      out  1  to master: chip select, held until m_rdy
//  m_we      out  1  to master: write enable
//  m_addr    out  8  to master: register select
//  m_din     out  8  to master: write data
//  m_dout    in   8  from master: read data
//  m_rdy     in   1  from master: completion, sampled while m_cs high
//  busy      out  1  high in any state except IDLE
// BEHAVIOUR
//  Reset (rst=0):
//   - state=IDLE; all outputs 0.
//   - last-winner reg selects B, so A wins first tie when A_FIRST=1.
//  States:
//   - IDLE: no grant, m_cs=0.
//     If any cs is high, pick winner (round-robin vs last winner), go GRANT.
//     Winner registered; m_cs rises the cycle after the request is seen.
//   - GRANT: m_* = registered copy of winner's we/addr/din, captured on entry.
//     Mid-transfer requester changes are ignored.
//     Timeout counter clears on entry and increments each cycle.
//     On m_rdy: winner rdy=1 for one cycle, winner dout=m_dout (registered), err=0.
//     Then go GAP.
//     If the counter reaches all-ones before m_rdy: winner rdy=1, err=1, dout=0x00.
//     Then go GAP.
//   - GAP: exactly one cycle with m_cs=0, so the master sees cs drop.
//     m_rdy in GAP or IDLE is ignored.
//     Then: if winner's lock=1 and its cs=1, re-GRANT the same port.
//     Otherwise apply round-robin among active cs; if none, go IDLE.
//  Latency:
//   - Uncontended request to rdy = 1 (arb) + master latency + 1 (registered rdy).
//  Fairness:
//   - Without lock, with both ports continuously requesting, grants alternate A,B,A,B.
//   - A locked port can starve the other; lock is sampled only in GAP.
//  Other rules:
//   - Loser's rdy/err stay 0; its dout holds its last value.
//   - Simultaneous m_rdy and timeout terminal count: m_rdy wins, err=0.
//   - Requester dropping cs while granted: transfer still completes; rdy pulses anyway.
//   - Async reset mid-GRANT: m_cs drops immediately; no rdy is issued.
//  busy:
//   - Combinational from state: 0 in IDLE, 1 otherwise.
// TESTING
//  1. A writes 0x5A to 0x09; master answers rdy 3 cycles after m_cs.
//     -> m_addr=0x09, m_din=0x5A, m_we=1; a_rdy=1 one cycle; a_err=0; b_rdy never.
//  2. A and B request the same cycle after reset, both held for 4 transfers.
//     -> order A,B,A,B; each m_cs preceded by one low GAP cycle.
//  3. A holds a_lock=1 for 3 reads while B requests.
//     -> A granted 3 times back-to-back; B granted next; a_dout matches m_dout each time.
//  4. B request, master never asserts m_rdy, TO_BITS=4.
//     -> b_rdy=1, b_err=1, b_dout=0x00 on the 15th grant cycle; then GAP, IDLE.
//  5. m_rdy coincides with timeout terminal count. -> err=0, data returned.
//  6. rst pulsed low mid-GRANT. -> m_cs=0 and busy=0 asynchronously; no rdy pulse;
//     the next request after release is served normally.

Source files
------------

// File: rtl/wb_host_arb.sv
// Two-port round-robin arbiter in front of the single 8-bit wishbone register port.
// Port A (CPU) and port B (engine) share the master; a per-port lock and a grant watchdog are provided.
module wb_host_arb #(
    parameter int TO_BITS = 8,
    parameter bit A_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_cs,
    input  logic       a_we,
    input  logic       a_lock,
    input  logic [7:0] a_addr,
    input  logic [7:0] a_din,
    output logic [7:0] a_dout,
    output logic       a_rdy,
    output logic       a_err,
    input  logic       b_cs,
    input  logic       b_we,
    input  logic       b_lock,
    input  logic [7:0] b_addr,
    input  logic [7:0] b_din,
    output logic [7:0] b_dout,
    output logic       b_rdy,
    output logic       b_err,
    output logic       m_cs,
    output logic       m_we,
    output logic [7:0] m_addr,
    output logic [7:0] m_din,
    input  logic [7:0] m_dout,
    input  logic       m_rdy,
    output logic       busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [TO_BITS-1:0] TO_ONE  = TO_BITS'(1'b1);
    // All-ones minus one: the counter reaches all-ones on the edge that ends this cycle.
    localparam logic [TO_BITS-1:0] TO_LAST = ~TO_ONE;

    state_t             state_r;
    state_t             state_nx_s;
    logic               win_r;      // 0 = port A, 1 = port B
    logic               last_r;     // last winner, drives round-robin
    logic [TO_BITS-1:0] to_cnt_r;
    logic               start_s;
    logic               sel_s;
    logic               done_s;
    logic               timeout_s;
    logic               rr_b_s;
    logic               lock_hold_s;

    assign busy = (state_r != IDLE);

    // Next-state and grant/terminate decisions.
    always_comb begin
        state_nx_s  = state_r;
        start_s     = 1'b0;
        sel_s       = win_r;
        done_s      = 1'b0;
        timeout_s   = 1'b0;
        rr_b_s      = b_cs & (~a_cs | ~last_r);
        lock_hold_s = win_r ? (b_lock & b_cs) : (a_lock & a_cs);
        case (state_r)
            IDLE: begin
                if (a_cs | b_cs) begin
                    start_s    = 1'b1;
                    sel_s      = rr_b_s;
                    state_nx_s = GRANT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            GRANT: begin
                if (m_rdy) begin
                    done_s     = 1'b1;
                    state_nx_s = GAP;
                end else if (to_cnt_r == TO_LAST) begin
                    done_s     = 1'b1;
                    timeout_s  = 1'b1;
                    state_nx_s = GAP;
                end else begin
                    state_nx_s = GRANT;
                end
            end
            GAP: begin
                if (lock_hold_s) begin
                    start_s    = 1'b1;
                    sel_s      = win_r;
                    state_nx_s = GRANT;
                end else if (a_cs | b_cs) begin
                    start_s    = 1'b1;
                    sel_s      = rr_b_s;
                    state_nx_s = GRANT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Grant capture, watchdog and completion outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_r    <= 1'b0;
            last_r   <= A_FIRST;
            to_cnt_r <= {TO_BITS{1'b0}};
            m_cs     <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= 8'h00;
            m_din    <= 8'h00;
            a_rdy    <= 1'b0;
            a_err    <= 1'b0;
            a_dout   <= 8'h00;
            b_rdy    <= 1'b0;
            b_err    <= 1'b0;
            b_dout   <= 8'h00;
        end else begin
            a_rdy <= 1'b0;
            a_err <= 1'b0;
            b_rdy <= 1'b0;
            b_err <= 1'b0;
            if (start_s) begin
                win_r    <= sel_s;
                last_r   <= sel_s;
                to_cnt_r <= {TO_BITS{1'b0}};
                m_cs     <= 1'b1;
                m_we     <= sel_s ? b_we   : a_we;
                m_addr   <= sel_s ? b_addr : a_addr;
                m_din    <= sel_s ? b_din  : a_din;
            end else if (state_r == GRANT) begin
                to_cnt_r <= to_cnt_r + TO_ONE;
            end
            if (done_s) begin
                m_cs <= 1'b0;
                if (win_r) begin
                    b_rdy  <= 1'b1;
                    b_err  <= timeout_s;
                    b_dout <= timeout_s ? 8'h00 : m_dout;
                end else begin
                    a_rdy  <= 1'b1;
                    a_err  <= timeout_s;
                    a_dout <= timeout_s ? 8'h00 : m_dout;
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_host_arb.sv
// Randomized bench for wb_host_arb: two requesters and a master with random latency,
// checked against a transaction-level timing model of the arbitration rules.
module tb_wb_host_arb;
    logic       clk = 1'b0;
    logic       rst;
    logic       a_cs, a_we, a_lock, b_cs, b_we, b_lock;
    logic [7:0] a_addr, a_din, b_addr, b_din, a_dout, b_dout;
    logic       a_rdy, a_err, b_rdy, b_err;
    logic       m_cs, m_we, m_rdy, busy;
    logic [7:0] m_addr, m_din, m_dout;

    always #5 clk = ~clk;

    wb_host_arb #(.TO_BITS(4), .A_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst),
        .a_cs(a_cs), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout), .a_rdy(a_rdy), .a_err(a_err),
        .b_cs(b_cs), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_din(b_din),
        .b_dout(b_dout), .b_rdy(b_rdy), .b_err(b_err),
        .m_cs(m_cs), .m_we(m_we), .m_addr(m_addr), .m_din(m_din),
        .m_dout(m_dout), .m_rdy(m_rdy), .busy(busy)
    );

    typedef struct packed {
        logic       we;
        logic       lock;
        logic [7:0] addr;
        logic [7:0] din;
    } req_t;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Model: index 0 = port A, 1 = port B.
    bit         pend [2];
    req_t       req [2];
    req_t       snap;
    bit         act, who, start_who, last;
    int         g, lat, done_at, gap_obs, start_at;
    logic [7:0] mdata;
    logic [7:0] exp_dout [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.we   = 1'($urandom);
        r.lock = ($urandom_range(9) < 3);
        r.addr = 8'($urandom);
        r.din  = 8'($urandom);
        return r;
    endfunction

    task automatic apply_req();
        a_cs = pend[0]; a_we = req[0].we; a_lock = req[0].lock; a_addr = req[0].addr; a_din = req[0].din;
        b_cs = pend[1]; b_we = req[1].we; b_lock = req[1].lock; b_addr = req[1].addr; b_din = req[1].din;
    endtask

    task automatic model_reset();
        pend[0] = 1'b0; pend[1] = 1'b0;
        req[0] = '0; req[1] = '0;
        act = 1'b0; who = 1'b0; last = 1'b1;
        start_at = -1; gap_obs = -10; done_at = -1; g = -100; lat = 0;
        exp_dout[0] = 8'h00; exp_dout[1] = 8'h00;
        apply_req();
        m_rdy = 1'b0; m_dout = 8'h00;
    endtask

    task automatic step();
        bit rdy_e [2];
        bit err_e [2];
        bit fin;
        @(posedge clk);
        #1;
        cyc++;
        rdy_e = '{1'b0, 1'b0};
        err_e = '{1'b0, 1'b0};
        fin   = 1'b0;
        if (act && cyc == done_at) begin
            fin        = 1'b1;
            act        = 1'b0;
            gap_obs    = cyc;
            rdy_e[who] = 1'b1;
            err_e[who] = (lat > 14);
            exp_dout[who] = (lat > 14) ? 8'h00 : mdata;
        end
        if (start_at == cyc) begin
            act = 1'b1; g = cyc; who = start_who; start_at = -1;
            case ($urandom_range(9))
                0:       lat = 14;
                1:       lat = 20;
                default: lat = int'($urandom_range(6));
            endcase
            done_at = g + ((lat < 14) ? lat : 14) + 1;
            mdata   = 8'($urandom);
        end
        check_eq("m_cs", {31'd0, m_cs}, {31'd0, act});
        check_eq("busy", {31'd0, busy}, {31'd0, (act || cyc == gap_obs)});
        if (act) check_eq("m_req", {m_we, m_addr, m_din}, {snap.we, snap.addr, snap.din});
        check_eq("a_resp", {a_rdy, a_err, a_dout}, {rdy_e[0], err_e[0], exp_dout[0]});
        check_eq("b_resp", {b_rdy, b_err, b_dout}, {rdy_e[1], err_e[1], exp_dout[1]});

        // Requesters: served port may reissue at once; winner may abandon mid-grant.
        if (fin) pend[who] = 1'b0;
        if (act && pend[who] && $urandom_range(29) == 0) begin
            pend[who] = 1'b0;
            req[who]  = rand_req();
        end
        for (int p = 0; p < 2; p++) begin
            if (!pend[p] && !(act && who == p[0]) &&
                ($urandom_range(99) < ((fin && who == p[0]) ? 70 : 20))) begin
                pend[p] = 1'b1;
                req[p]  = rand_req();
            end
        end
        apply_req();

        // Arbitration outcome expected on the next edge.
        if (!act && (pend[0] || pend[1])) begin
            if (cyc == gap_obs && pend[who] && req[who].lock) start_who = who;
            else if (pend[0] && pend[1])                      start_who = ~last;
            else                                              start_who = pend[1];
            start_at = cyc + 1;
            last     = start_who;
            snap     = req[start_who];
        end

        // Master: one rdy pulse after the chosen latency; noise while not granted.
        if (act && cyc == g + lat) begin
            m_rdy  = 1'b1;
            m_dout = mdata;
        end else begin
            m_rdy  = act ? 1'b0 : 1'($urandom);
            m_dout = 8'($urandom);
        end
    endtask

    initial begin
        int waits;
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_ctl", {m_cs, m_we, m_addr, m_din, a_rdy, a_err, b_rdy, b_err, busy}, 32'd0);
        check_eq("rst_dout", {a_dout, b_dout}, 32'd0);
        rst = 1'b1;

        repeat (1500) step();

        waits = 0;
        while (!(act && cyc > g) && waits < 2000) begin
            step();
            waits++;
        end
        check_eq("grant_seen", {31'd0, act}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("rst_async", {m_cs, busy, a_rdy, b_rdy}, 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_hold", {m_cs, busy, a_rdy, a_err, b_rdy, b_err, a_dout, b_dout}, 32'd0);
        rst = 1'b1;

        repeat (1500) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
